sc_datapath_bus_sequencer: RTL and testbench

Sequences one register-transfer micro-operation at a time through the microarchitecture datapath. It accepts a command (source A, source B, destination register indices) over a valid/ready handshake. It then drives one-hot selection codes to the A-bus and B-bus register multiplexers, waits for the ALU, and issues a one-hot write enable to the destination register. It sits between the control unit and the register file / bus multiplexers.

---
 rtl/sc_datapath_bus_sequencer.sv | 145 ++++++++++++++
 tb/tb_sc_datapath_bus_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_datapath_bus_sequencer.sv
// Datapath bus sequencer: runs one register-transfer micro-operation at a
// time. It drives the A/B bus selects, starts the ALU, waits out the ALU
// latency, then issues the destination write enable.
//
// Handshake: a command transfers on a rising edge where CMD_VALID and
// CMD_READY are both high. READY is combinational (IDLE, no flush, out of
// reset). Command fields are captured at that edge, and later changes to the
// inputs are ignored.
module sc_datapath_bus_sequencer #(
    parameter int NUM_REGS    = 38,
    parameter int IDX_WIDTH   = 6,
    parameter int ALU_LATENCY = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   SC_DPSEQ_CLOCK_50,
    input  logic                   SC_DPSEQ_RESET_InLow,
    input  logic                   SC_DPSEQ_CMD_VALID_In,
    output logic                   SC_DPSEQ_CMD_READY_Out,
    input  logic [IDX_WIDTH-1:0]   SC_DPSEQ_CMD_SRCA_In,
    input  logic [IDX_WIDTH-1:0]   SC_DPSEQ_CMD_SRCB_In,
    input  logic [IDX_WIDTH-1:0]   SC_DPSEQ_CMD_DEST_In,
    input  logic                   SC_DPSEQ_CMD_WBEN_In,
    input  logic                   SC_DPSEQ_FLUSH_In,
    output logic [NUM_REGS-1:0]    SC_DPSEQ_BUSA_SEL_Out,
    output logic [NUM_REGS-1:0]    SC_DPSEQ_BUSB_SEL_Out,
    output logic [NUM_REGS-1:0]    SC_DPSEQ_DEST_WR_Out,
    output logic                   SC_DPSEQ_ALU_START_Out,
    output logic                   SC_DPSEQ_BUSY_Out,
    output logic                   SC_DPSEQ_DONE_Out,
    output logic                   SC_DPSEQ_ERR_Out,
    output logic [COUNT_WIDTH-1:0] SC_DPSEQ_OPCOUNT_Out,
    output logic [1:0]             SC_DPSEQ_DBG_STATE_Out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [IDX_WIDTH:0]   NREGS    = (IDX_WIDTH + 1)'(NUM_REGS);
    localparam logic [3:0]           LAT_INIT = 4'(ALU_LATENCY - 1);
    localparam logic [NUM_REGS-1:0]  ONE      = {{(NUM_REGS - 1){1'b0}}, 1'b1};

    state_t               state;
    logic [3:0]           lat_cnt;
    logic [IDX_WIDTH-1:0] dest_q;
    logic                 wben_q;
    logic                 accept;
    logic                 idx_bad;

    // Command acceptance and index legality; READY is forced low during reset.
    always_comb begin
        SC_DPSEQ_CMD_READY_Out = SC_DPSEQ_RESET_InLow && (state == IDLE) && !SC_DPSEQ_FLUSH_In;
        accept  = SC_DPSEQ_CMD_VALID_In && SC_DPSEQ_CMD_READY_Out;
        idx_bad = ({1'b0, SC_DPSEQ_CMD_SRCA_In} >= NREGS) ||
                  ({1'b0, SC_DPSEQ_CMD_SRCB_In} >= NREGS) ||
                  ({1'b0, SC_DPSEQ_CMD_DEST_In} >= NREGS);
    end

    assign SC_DPSEQ_DBG_STATE_Out = state;

    // Sequencer FSM with all datapath controls registered alongside the state.
    always_ff @(posedge SC_DPSEQ_CLOCK_50 or negedge SC_DPSEQ_RESET_InLow) begin
        if (!SC_DPSEQ_RESET_InLow) begin
            state                  <= IDLE;
            lat_cnt                <= '0;
            dest_q                 <= '0;
            wben_q                 <= 1'b0;
            SC_DPSEQ_BUSA_SEL_Out  <= '0;
            SC_DPSEQ_BUSB_SEL_Out  <= '0;
            SC_DPSEQ_DEST_WR_Out   <= '0;
            SC_DPSEQ_ALU_START_Out <= 1'b0;
            SC_DPSEQ_BUSY_Out      <= 1'b0;
            SC_DPSEQ_DONE_Out      <= 1'b0;
            SC_DPSEQ_ERR_Out       <= 1'b0;
            SC_DPSEQ_OPCOUNT_Out   <= '0;
        end else begin
            SC_DPSEQ_ALU_START_Out <= 1'b0;
            SC_DPSEQ_DONE_Out      <= 1'b0;
            SC_DPSEQ_ERR_Out       <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (idx_bad) begin
                            // Illegal index: flag it and drive nothing.
                            SC_DPSEQ_ERR_Out <= 1'b1;
                        end else begin
                            state                  <= READ;
                            SC_DPSEQ_BUSY_Out      <= 1'b1;
                            SC_DPSEQ_BUSA_SEL_Out  <= ONE << SC_DPSEQ_CMD_SRCA_In;
                            SC_DPSEQ_BUSB_SEL_Out  <= ONE << SC_DPSEQ_CMD_SRCB_In;
                            SC_DPSEQ_ALU_START_Out <= 1'b1;
                            dest_q                 <= SC_DPSEQ_CMD_DEST_In;
                            wben_q                 <= SC_DPSEQ_CMD_WBEN_In;
                        end
                    end
                end
                READ: begin
                    if (SC_DPSEQ_FLUSH_In) begin
                        state                 <= IDLE;
                        SC_DPSEQ_BUSY_Out     <= 1'b0;
                        SC_DPSEQ_BUSA_SEL_Out <= '0;
                        SC_DPSEQ_BUSB_SEL_Out <= '0;
                    end else begin
                        state   <= EXEC;
                        lat_cnt <= LAT_INIT;
                    end
                end
                EXEC: begin
                    if (SC_DPSEQ_FLUSH_In) begin
                        state                 <= IDLE;
                        SC_DPSEQ_BUSY_Out     <= 1'b0;
                        SC_DPSEQ_BUSA_SEL_Out <= '0;
                        SC_DPSEQ_BUSB_SEL_Out <= '0;
                    end else if (lat_cnt == 4'd0) begin
                        state             <= WRITE;
                        SC_DPSEQ_DONE_Out <= 1'b1;
                        // Register 0 is hard-wired zero, so its write is dropped.
                        if (wben_q && (dest_q != '0)) begin
                            SC_DPSEQ_DEST_WR_Out <= ONE << dest_q;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                WRITE: begin
                    // A flush seen here withholds the count; the enable and
                    // completion already driven in this cycle stand.
                    state                 <= IDLE;
                    SC_DPSEQ_BUSY_Out     <= 1'b0;
                    SC_DPSEQ_BUSA_SEL_Out <= '0;
                    SC_DPSEQ_BUSB_SEL_Out <= '0;
                    SC_DPSEQ_DEST_WR_Out  <= '0;
                    if (!SC_DPSEQ_FLUSH_In && (SC_DPSEQ_OPCOUNT_Out != '1)) begin
                        SC_DPSEQ_OPCOUNT_Out <= SC_DPSEQ_OPCOUNT_Out + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_datapath_bus_sequencer.sv
// Bench for sc_datapath_bus_sequencer. Two instances run side by side:
// instance 0 with ALU latency 1 and a 16-bit counter, instance 1 with ALU
// latency 3 and a 2-bit counter. The reference model tracks each operation
// as "accepted at cycle a" and derives every output from the cycle offset.
module tb_sc_datapath_bus_sequencer;

    localparam int NR = 38;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       valid[2], flush[2], wben[2];
    logic [5:0] srca[2], srcb[2], dest[2];
    logic       ready[2], alu_start[2], busy[2], done[2], err[2];
    logic [NR-1:0] busa[2], busb[2], dwr[2];
    logic [1:0] dbg[2];
    logic [15:0] opc0;
    logic [1:0]  opc1;

    sc_datapath_bus_sequencer #(.NUM_REGS(NR), .IDX_WIDTH(6), .ALU_LATENCY(1), .COUNT_WIDTH(16)) dut0 (
        .SC_DPSEQ_CLOCK_50(clk), .SC_DPSEQ_RESET_InLow(rst_n),
        .SC_DPSEQ_CMD_VALID_In(valid[0]), .SC_DPSEQ_CMD_READY_Out(ready[0]),
        .SC_DPSEQ_CMD_SRCA_In(srca[0]), .SC_DPSEQ_CMD_SRCB_In(srcb[0]),
        .SC_DPSEQ_CMD_DEST_In(dest[0]), .SC_DPSEQ_CMD_WBEN_In(wben[0]),
        .SC_DPSEQ_FLUSH_In(flush[0]),
        .SC_DPSEQ_BUSA_SEL_Out(busa[0]), .SC_DPSEQ_BUSB_SEL_Out(busb[0]),
        .SC_DPSEQ_DEST_WR_Out(dwr[0]), .SC_DPSEQ_ALU_START_Out(alu_start[0]),
        .SC_DPSEQ_BUSY_Out(busy[0]), .SC_DPSEQ_DONE_Out(done[0]),
        .SC_DPSEQ_ERR_Out(err[0]), .SC_DPSEQ_OPCOUNT_Out(opc0),
        .SC_DPSEQ_DBG_STATE_Out(dbg[0]));

    sc_datapath_bus_sequencer #(.NUM_REGS(NR), .IDX_WIDTH(6), .ALU_LATENCY(3), .COUNT_WIDTH(2)) dut1 (
        .SC_DPSEQ_CLOCK_50(clk), .SC_DPSEQ_RESET_InLow(rst_n),
        .SC_DPSEQ_CMD_VALID_In(valid[1]), .SC_DPSEQ_CMD_READY_Out(ready[1]),
        .SC_DPSEQ_CMD_SRCA_In(srca[1]), .SC_DPSEQ_CMD_SRCB_In(srcb[1]),
        .SC_DPSEQ_CMD_DEST_In(dest[1]), .SC_DPSEQ_CMD_WBEN_In(wben[1]),
        .SC_DPSEQ_FLUSH_In(flush[1]),
        .SC_DPSEQ_BUSA_SEL_Out(busa[1]), .SC_DPSEQ_BUSB_SEL_Out(busb[1]),
        .SC_DPSEQ_DEST_WR_Out(dwr[1]), .SC_DPSEQ_ALU_START_Out(alu_start[1]),
        .SC_DPSEQ_BUSY_Out(busy[1]), .SC_DPSEQ_DONE_Out(done[1]),
        .SC_DPSEQ_ERR_Out(err[1]), .SC_DPSEQ_OPCOUNT_Out(opc1),
        .SC_DPSEQ_DBG_STATE_Out(dbg[1]));

    // ---------------- scoreboard / reference model ----------------
    int n_cmp = 0;
    int n_err = 0;

    int m_cyc;
    int m_lat[2]  = '{1, 3};
    int m_cmax[2] = '{65535, 3};
    bit m_active[2], m_errx[2], m_accepted[2];
    int m_acc[2], m_opc[2], m_a[2], m_b[2], m_d[2];
    bit m_w[2];
    int done_cyc[$];
    bit rec_done;

    function automatic logic [NR-1:0] onehot(int i);
        logic [NR-1:0] v;
        v = '0;
        if (i >= 0 && i < NR) v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] opc_of(int k);
        return (k == 0) ? {48'd0, opc0} : {62'd0, opc1};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 0; m_errx[k] = 0; m_accepted[k] = 0; m_opc[k] = 0; m_acc[k] = 0;
        end
        m_cyc = 0;
    endtask

    // Applies the rules of one rising edge to the model of instance k.
    task automatic model_edge(int k);
        int p;
        m_errx[k] = 0;
        m_accepted[k] = 0;
        if (m_active[k]) begin
            p = m_cyc - m_acc[k];
            if (flush[k]) m_active[k] = 0;
            else if (p == 2 + m_lat[k]) begin
                m_active[k] = 0;
                if (m_opc[k] < m_cmax[k]) m_opc[k]++;
            end
        end else if (valid[k] && !flush[k]) begin
            m_accepted[k] = 1;
            if (srca[k] >= NR || srcb[k] >= NR || dest[k] >= NR) m_errx[k] = 1;
            else begin
                m_active[k] = 1; m_acc[k] = m_cyc;
                m_a[k] = int'(srca[k]); m_b[k] = int'(srcb[k]); m_d[k] = int'(dest[k]); m_w[k] = wben[k];
            end
        end
    endtask

    task automatic compare_outputs(int k);
        int p;
        bit wr_cyc;
        string s;
        s = $sformatf("d%0d_c%0d_", k, m_cyc);
        p = m_cyc - m_acc[k];
        wr_cyc = m_active[k] && (p == 2 + m_lat[k]);
        check({s, "busa"},  busa[k],      m_active[k] ? onehot(m_a[k]) : '0);
        check({s, "busb"},  busb[k],      m_active[k] ? onehot(m_b[k]) : '0);
        check({s, "destwr"}, dwr[k],      (wr_cyc && m_w[k] && m_d[k] != 0) ? onehot(m_d[k]) : '0);
        check({s, "alustart"}, alu_start[k], m_active[k] && p == 1);
        check({s, "done"},  done[k],      wr_cyc);
        check({s, "busy"},  busy[k],      m_active[k]);
        check({s, "err"},   err[k],       m_errx[k]);
        check({s, "opcount"}, opc_of(k),  m_opc[k]);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d_c%0d_ready", k, m_cyc), ready[k], !m_active[k] && !flush[k]);
            model_edge(k);
        end
        m_cyc++;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) compare_outputs(k);
        if (rec_done && done[0]) done_cyc.push_back(m_cyc);
        @(negedge clk);
    endtask

    task automatic set_cmd(int k, bit v, int a, int b, int d, bit w);
        valid[k] = v; srca[k] = 6'(a); srcb[k] = 6'(b); dest[k] = 6'(d); wben[k] = w;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            set_cmd(k, 0, 0, 0, 0, 0);
            flush[k] = 0;
        end
    endtask

    // Issues one command to instance k and runs until the model is idle again.
    task automatic run_cmd(int k, int a, int b, int d, bit w);
        set_cmd(k, 1, a, b, d, w);
        step();
        valid[k] = 0;
        for (int i = 0; i < 20 && m_active[k]; i++) step();
    endtask

    task automatic apply_reset(int cycles);
        rst_n = 1'b0;
        valid[0] = 1; valid[1] = 1;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rst%0d_ready", k), ready[k], 1'b0);
                check($sformatf("rst%0d_busa", k), busa[k], '0);
                check($sformatf("rst%0d_destwr", k), dwr[k], '0);
                check($sformatf("rst%0d_busy", k), busy[k], 1'b0);
                check($sformatf("rst%0d_opcount", k), opc_of(k), 0);
            end
            @(negedge clk);
        end
        idle_all();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        idle_all();
        rec_done = 0;
        @(negedge clk);
        apply_reset(3);
        step();
        step();

        // Basic operation on the latency-1 instance.
        run_cmd(0, 5, 17, 9, 1);
        check("basic_opcount_const", opc_of(0), 1);

        // Write to register 0 is suppressed; compare-only writes nothing.
        run_cmd(0, 3, 4, 0, 1);
        run_cmd(0, 7, 8, 12, 0);
        check("cmp_only_opcount_const", opc_of(0), 3);

        // Illegal source index.
        run_cmd(0, 2, 40, 6, 1);
        step();
        check("illegal_opcount_const", opc_of(0), 3);

        // Flush in the second EXEC cycle of the latency-3 instance.
        set_cmd(1, 1, 10, 11, 12, 1);
        step();
        valid[1] = 0;
        step();
        step();
        flush[1] = 1;
        step();
        flush[1] = 0;
        check("flush_busy_const", busy[1], 1'b0);
        check("flush_opcount_const", opc_of(1), 0);

        // Flush with VALID in IDLE: command must not be taken.
        set_cmd(1, 1, 1, 2, 3, 1);
        flush[1] = 1;
        step();
        idle_all();
        step();
        check("flush_idle_busy_const", busy[1], 1'b0);

        // Back-to-back: VALID held across four commands on instance 0.
        done_cyc.delete();
        rec_done = 1;
        for (int c = 0; c < 4; c++) begin
            set_cmd(0, 1, 1 + c, 20 + c, 30 + c, 1);
            step();
            for (int i = 0; i < 10 && !m_accepted[0]; i++) step();
        end
        valid[0] = 0;
        for (int i = 0; i < 10 && m_active[0]; i++) step();
        rec_done = 0;
        check("b2b_done_count", done_cyc.size(), 4);
        for (int i = 1; i < done_cyc.size(); i++)
            check($sformatf("b2b_done_gap%0d", i), done_cyc[i] - done_cyc[i-1], 4);

        // Saturation of the 2-bit counter after five operations.
        for (int c = 0; c < 5; c++) run_cmd(1, c, c + 1, c + 2, 1);
        check("sat_opcount_const", opc_of(1), 3);

        // Reset in the middle of an operation: outputs clear immediately.
        set_cmd(0, 1, 6, 7, 8, 1);
        step();
        valid[0] = 0;
        rst_n = 1'b0;
        #1;
        check("midrst_busa", busa[0], '0);
        check("midrst_busy", busy[0], 1'b0);
        @(negedge clk);
        apply_reset(1);
        step();

        // Random traffic on both instances; fields wander every cycle.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                set_cmd(k, $urandom_range(0, 1),
                        ($urandom_range(0, 9) == 0) ? $urandom_range(38, 63) : $urandom_range(0, 37),
                        $urandom_range(0, 37),
                        ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 37),
                        $urandom_range(0, 3) != 0);
                flush[k] = ($urandom_range(0, 11) == 0);
            end
            step();
        end
        idle_all();
        for (int i = 0; i < 8; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
